// File: rtl/bra_exec_unit.sv
// -----------------------------------------------------------------------------
// bra_exec_unit
//   Branch functional unit behind the branch reservation station. A dispatch
//   (Dest_in != 0) is registered into stage S1. S1 evaluates the condition,
//   the next PC and the link value. The result is then pushed into an in-order
//   result FIFO. The FIFO head is offered on the branch CDB channel under a
//   req/grant handshake.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   rollback             flush S1 and the FIFO (stat counters are kept)
//   Op_in..Dest_in       dispatch from the RS; Dest_in != 0 marks a valid op
//   func_busy            RS must not dispatch (combinational)
//   cdb_req / cdb_grant  head-valid request / accept (pop) handshake
//   CDB_BRA_ROB_index    head ROB index, 0 when idle
//   CDB_BRA_data         head link value (PC+4 for JAL/JALR), 0 when idle
//   bra_taken            head taken flag, 0 when idle
//   bra_target           head next PC, 0 when idle
//   stat_branches        popped conditional branches (BRA_STATS_EN only)
//   stat_taken           popped taken conditional branches (BRA_STATS_EN only)
//
// Build option
//   BRA_STATS_EN  when defined, the two wrapping 32-bit stat counters are built.
//                 When undefined, both stat outputs are tied to 0.
// -----------------------------------------------------------------------------
module bra_exec_unit #(
  parameter int DEPTH           = 2,
  parameter int BRA_OP_WIDTH    = 4,
  parameter int ROB_ENTRY_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rollback,
  input  logic [BRA_OP_WIDTH-1:0]    Op_in,
  input  logic [31:0]                Vj_in,
  input  logic [31:0]                Vk_in,
  input  logic [31:0]                PC_in,
  input  logic [31:0]                Offset_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] Dest_in,
  output logic                       func_busy,
  output logic                       cdb_req,
  input  logic                       cdb_grant,
  output logic [ROB_ENTRY_WIDTH-1:0] CDB_BRA_ROB_index,
  output logic [31:0]                CDB_BRA_data,
  output logic                       bra_taken,
  output logic [31:0]                bra_target,
  output logic [31:0]                stat_branches,
  output logic [31:0]                stat_taken
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [BRA_OP_WIDTH-1:0] OP_BEQ  = BRA_OP_WIDTH'(1);
  localparam logic [BRA_OP_WIDTH-1:0] OP_BNE  = BRA_OP_WIDTH'(2);
  localparam logic [BRA_OP_WIDTH-1:0] OP_BLT  = BRA_OP_WIDTH'(3);
  localparam logic [BRA_OP_WIDTH-1:0] OP_BGE  = BRA_OP_WIDTH'(4);
  localparam logic [BRA_OP_WIDTH-1:0] OP_BLTU = BRA_OP_WIDTH'(5);
  localparam logic [BRA_OP_WIDTH-1:0] OP_BGEU = BRA_OP_WIDTH'(6);
  localparam logic [BRA_OP_WIDTH-1:0] OP_JAL  = BRA_OP_WIDTH'(7);
  localparam logic [BRA_OP_WIDTH-1:0] OP_JALR = BRA_OP_WIDTH'(8);

  // ---------------------------------------------------------------------------
  // Stage S1
  // ---------------------------------------------------------------------------
  logic                       s1_valid;
  logic [BRA_OP_WIDTH-1:0]    s1_op;
  logic [31:0]                s1_vj, s1_vk, s1_pc, s1_off;
  logic [ROB_ENTRY_WIDTH-1:0] s1_dest;

  logic        s1_taken;
  logic [31:0] s1_target;
  logic [31:0] s1_data;
  logic [31:0] s1_link;
  logic [31:0] s1_jalr_sum;

  logic dest_nz;
  assign dest_nz = (Dest_in != '0);

  // Payload registers need no reset: s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (dest_nz) begin
      s1_op   <= Op_in;
      s1_vj   <= Vj_in;
      s1_vk   <= Vk_in;
      s1_pc   <= PC_in;
      s1_off  <= Offset_in;
      s1_dest <= Dest_in;
    end
  end

  always_comb begin
    s1_taken = 1'b0;
    case (s1_op)
      OP_BEQ:          s1_taken = (s1_vj == s1_vk);
      OP_BNE:          s1_taken = (s1_vj != s1_vk);
      OP_BLT:          s1_taken = ($signed(s1_vj) <  $signed(s1_vk));
      OP_BGE:          s1_taken = ($signed(s1_vj) >= $signed(s1_vk));
      OP_BLTU:         s1_taken = (s1_vj <  s1_vk);
      OP_BGEU:         s1_taken = (s1_vj >= s1_vk);
      OP_JAL, OP_JALR: s1_taken = 1'b1;
      default:         s1_taken = 1'b0;
    endcase
  end

  assign s1_link     = s1_pc + 32'd4;
  assign s1_jalr_sum = s1_vj + s1_off;

  always_comb begin
    s1_data   = 32'd0;
    s1_target = s1_link;
    if (s1_op == OP_JALR) begin
      s1_target = s1_jalr_sum & ~32'd1;
      s1_data   = s1_link;
    end else if (s1_op == OP_JAL) begin
      s1_target = s1_pc + s1_off;
      s1_data   = s1_link;
    end else if (s1_taken) begin
      s1_target = s1_pc + s1_off;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [ROB_ENTRY_WIDTH-1:0] fifo_idx    [DEPTH];
  logic [31:0]                fifo_data   [DEPTH];
  logic                       fifo_taken  [DEPTH];
  logic [31:0]                fifo_target [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop;

  assign push = s1_valid;
  assign pop  = cdb_req & cdb_grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Writing during a rollback/reset cycle is harmless: the pointers are
  // cleared in the same edge, so the entry is never read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]    <= s1_dest;
      fifo_data[wr_ptr]   <= s1_data;
      fifo_taken[wr_ptr]  <= s1_taken;
      fifo_target[wr_ptr] <= s1_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rollback) begin
      s1_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      s1_valid <= dest_nz;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Count the op on the RS output as well. A dispatch decided while busy was
  // low then always finds room, even with one more already in flight.
  logic [CNT_W:0] occ;
  assign occ       = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(dest_nz);
  assign func_busy = (occ >= (CNT_W+1)'(DEPTH));

  assign cdb_req           = (fifo_count != '0);
  assign CDB_BRA_ROB_index = cdb_req ? fifo_idx[rd_ptr]    : '0;
  assign CDB_BRA_data      = cdb_req ? fifo_data[rd_ptr]   : 32'd0;
  assign bra_taken         = cdb_req ? fifo_taken[rd_ptr]  : 1'b0;
  assign bra_target        = cdb_req ? fifo_target[rd_ptr] : 32'd0;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef BRA_STATS_EN
  logic        s1_cond;
  logic        fifo_cond [DEPTH];
  logic [31:0] stat_branches_q, stat_taken_q;

  assign s1_cond = (s1_op >= OP_BEQ) && (s1_op <= OP_BGEU);

  always_ff @(posedge clk) begin
    if (push) fifo_cond[wr_ptr] <= s1_cond;
  end

  // Reset clears the counters; rollback deliberately does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q <= 32'd0;
      stat_taken_q    <= 32'd0;
    end else if (!rollback && pop && fifo_cond[rd_ptr]) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (fifo_taken[rd_ptr]) stat_taken_q <= stat_taken_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`else
  assign stat_branches = 32'd0;
  assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_bra_exec_unit.sv
module tb_bra_exec_unit;
  localparam int DEPTH = 2;
  localparam int OPW   = 4;
  localparam int ROBW  = 5;
`ifdef BRA_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, rollback, cdb_grant;
  logic [OPW-1:0]  Op_in;
  logic [31:0]     Vj_in, Vk_in, PC_in, Offset_in;
  logic [ROBW-1:0] Dest_in;
  logic            func_busy, cdb_req, bra_taken;
  logic [ROBW-1:0] CDB_BRA_ROB_index;
  logic [31:0]     CDB_BRA_data, bra_target, stat_branches, stat_taken;

  always #5 clk = ~clk;

  bra_exec_unit #(.DEPTH(DEPTH), .BRA_OP_WIDTH(OPW), .ROB_ENTRY_WIDTH(ROBW)) dut (
    .clk(clk), .rst_n(rst_n), .rollback(rollback),
    .Op_in(Op_in), .Vj_in(Vj_in), .Vk_in(Vk_in), .PC_in(PC_in),
    .Offset_in(Offset_in), .Dest_in(Dest_in), .func_busy(func_busy),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .CDB_BRA_ROB_index(CDB_BRA_ROB_index), .CDB_BRA_data(CDB_BRA_data),
    .bra_taken(bra_taken), .bra_target(bra_target),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  typedef struct {
    logic [ROBW-1:0] idx;
    logic [31:0]     data;
    logic            taken;
    logic [31:0]     target;
    bit              cond;
    int              cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          allow = 1'b1;
  logic        gnt_mode = 1'b0;
  logic [31:0] exp_branches = 32'd0;
  logic [31:0] exp_taken = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference behaviour straight from the ISA rules.
  function automatic exp_t model(input logic [OPW-1:0] op, input logic [31:0] vj, vk, pc, off,
                                 input logic [ROBW-1:0] dest);
    exp_t        e;
    logic [31:0] sb;
    sb     = 32'h8000_0000;
    e.idx  = dest;
    e.cyc  = cyc;
    e.cond = (op >= 4'd1) && (op <= 4'd6);
    case (op)
      4'd1:       e.taken = (vj == vk);
      4'd2:       e.taken = (vj != vk);
      4'd3:       e.taken = ((vj ^ sb) < (vk ^ sb));   // sign flip turns signed order into unsigned
      4'd4:       e.taken = !((vj ^ sb) < (vk ^ sb));
      4'd5:       e.taken = (vj < vk);
      4'd6:       e.taken = !(vj < vk);
      4'd7, 4'd8: e.taken = 1'b1;
      default:    e.taken = 1'b0;
    endcase
    e.data = (op == 4'd7 || op == 4'd8) ? pc + 32'd4 : 32'd0;
    if (op == 4'd8)   e.target = (vj + off) & 32'hFFFF_FFFE;
    else if (e.taken) e.target = pc + off;
    else              e.target = pc + 32'd4;
    return e;
  endfunction

  task automatic drive(input logic [OPW-1:0] op, input logic [31:0] vj, vk, pc, off,
                       input logic [ROBW-1:0] dest, input logic rb, input logic gnt);
    @(posedge clk);
    #1;
    Op_in = op; Vj_in = vj; Vk_in = vk; PC_in = pc; Offset_in = off;
    Dest_in = dest; rollback = rb; cdb_grant = gnt;
    if (dest != '0) exp_q.push_back(model(op, vj, vk, pc, off, dest));
    #1 allow = !func_busy;
  endtask

  task automatic idle();
    drive('0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, gnt_mode);
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [31:0] vj, vk, pc, off,
                       input logic [ROBW-1:0] dest);
    int guard = 0;
    while (!allow && guard < 40) begin
      idle();
      guard++;
    end
    chk("issue_wait", 32'(allow), 32'd1);
    drive(op, vj, vk, pc, off, dest, 1'b0, gnt_mode);
  endtask

  task automatic drain();
    int guard = 0;
    gnt_mode = 1'b1;
    while ((exp_q.size() != 0 || cdb_req) && guard < 60) begin
      idle();
      guard++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: compares the head against the oldest expected result.
  always @(negedge clk) begin
    logic exp_req;
    exp_t e;
    exp_req = (exp_q.size() != 0) && (exp_q[0].cyc + 2 <= cyc);
    chk("cdb_req", 32'(cdb_req), 32'(exp_req));
    chk("func_busy", 32'(func_busy), 32'(exp_q.size() >= DEPTH));
    if (exp_req) begin
      chk("head_index", 32'(CDB_BRA_ROB_index), 32'(exp_q[0].idx));
      chk("head_data", CDB_BRA_data, exp_q[0].data);
      chk("head_taken", 32'(bra_taken), 32'(exp_q[0].taken));
      chk("head_target", bra_target, exp_q[0].target);
    end else begin
      chk("idle_outputs", 32'(CDB_BRA_ROB_index) | CDB_BRA_data | 32'(bra_taken) | bra_target, 32'd0);
    end
    chk("stat_branches", stat_branches, STATS ? exp_branches : 32'd0);
    chk("stat_taken", stat_taken, STATS ? exp_taken : 32'd0);
    checks++;
    if (rst_n && !rollback && dut.s1_valid && dut.fifo_count == 2'(DEPTH) && !(cdb_req && cdb_grant)) begin
      errors++;
      $display("FAIL overflow: push into full fifo, count %0d want < %0d", dut.fifo_count, DEPTH);
    end
    if (!rst_n || rollback) begin
      exp_q.delete();
      if (!rst_n) begin
        exp_branches = 32'd0;
        exp_taken    = 32'd0;
      end
    end else if (exp_req && cdb_grant) begin
      e = exp_q.pop_front();
      if (e.cond) begin
        exp_branches = exp_branches + 32'd1;
        if (e.taken) exp_taken = exp_taken + 32'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rollback = 1'b0; cdb_grant = 1'b0; Op_in = '0;
    Vj_in = 32'd0; Vk_in = 32'd0; PC_in = 32'd0; Offset_in = 32'd0; Dest_in = '0;
    idle(); idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req", 32'(cdb_req), 32'd0);
    chk("reset_busy", 32'(func_busy), 32'd0);
    chk("reset_index", 32'(CDB_BRA_ROB_index), 32'd0);

    // BEQ taken: head two cycles after dispatch, gone the cycle after
    gnt_mode = 1'b1;
    issue(4'd1, 32'd5, 32'd5, 32'h100, 32'h20, 5'd3);
    idle();
    @(negedge clk);
    chk("beq_latency_req", 32'(cdb_req), 32'd0);
    idle();
    @(negedge clk);
    chk("beq_req", 32'(cdb_req), 32'd1);
    chk("beq_index", 32'(CDB_BRA_ROB_index), 32'd3);
    chk("beq_data", CDB_BRA_data, 32'd0);
    chk("beq_taken", 32'(bra_taken), 32'd1);
    chk("beq_target", bra_target, 32'h120);
    idle();
    @(negedge clk);
    chk("beq_after_index", 32'(CDB_BRA_ROB_index), 32'd0);

    // Signed vs unsigned compare on the same operands
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8, 5'd4);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8, 5'd6);
    drain();

    // JALR target clears bit 0
    issue(4'd8, 32'h1003, 32'd0, 32'h200, 32'h10, 5'd7);
    idle(); idle();
    @(negedge clk);
    chk("jalr_index", 32'(CDB_BRA_ROB_index), 32'd7);
    chk("jalr_data", CDB_BRA_data, 32'h204);
    chk("jalr_target", bra_target, 32'h1012);
    chk("jalr_taken", 32'(bra_taken), 32'd1);
    drain();

    // Backpressure: no grant, two dispatches fill the unit
    gnt_mode = 1'b0;
    issue(4'd2, 32'd1, 32'd2, 32'h300, 32'h4, 5'd1);
    issue(4'd6, 32'd3, 32'd2, 32'h304, 32'h8, 5'd2);
    idle();
    @(negedge clk);
    chk("bp_busy", 32'(func_busy), 32'd1);
    idle(); idle();
    @(negedge clk);
    chk("bp_hold_index", 32'(CDB_BRA_ROB_index), 32'd1);
    drain();

    // Rollback with one buffered, S1 valid, plus concurrent dispatch and grant
    gnt_mode = 1'b0;
    issue(4'd1, 32'd0, 32'd0, 32'h500, 32'h10, 5'd1);
    issue(4'd7, 32'd0, 32'd0, 32'h504, 32'h40, 5'd2);
    drive(4'd7, 32'd0, 32'd0, 32'h508, 32'h40, 5'd9, 1'b1, 1'b1);
    drive('0, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rb_req", 32'(cdb_req), 32'd0);
    chk("rb_index", 32'(CDB_BRA_ROB_index), 32'd0);
    chk("rb_busy", 32'(func_busy), 32'd0);
    gnt_mode = 1'b1;
    issue(4'd2, 32'd1, 32'd1, 32'h600, 32'h10, 5'd5);
    idle(); idle();
    @(negedge clk);
    chk("rb_new_index", 32'(CDB_BRA_ROB_index), 32'd5);
    drain();

    // Randomized traffic with random grant and occasional rollback
    for (int n = 0; n < 400; n++) begin
      logic        rb, gnt;
      logic [31:0] vj;
      rb  = ($urandom_range(0, 39) == 0);
      gnt = 1'($urandom_range(0, 1));
      vj  = $urandom;
      if (allow && $urandom_range(0, 2) != 0)
        drive(4'($urandom_range(0, 8)), vj, ($urandom_range(0, 3) == 0) ? vj : $urandom,
              $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom_range(1, 31)), rb, gnt);
      else
        drive('0, 32'd0, 32'd0, 32'd0, 32'd0, '0, rb, gnt);
    end
    rollback = 1'b0;
    drain();

    // Statistics: 3 conditional pops (2 taken) plus one JAL, then reset mid-stream
    rst_n = 1'b0;
    idle(); idle();
    rst_n = 1'b1;
    gnt_mode = 1'b1;
    issue(4'd1, 32'd5, 32'd5, 32'h700, 32'h20, 5'd1);
    issue(4'd2, 32'd5, 32'd5, 32'h704, 32'h20, 5'd2);
    issue(4'd5, 32'd1, 32'd2, 32'h708, 32'h20, 5'd3);
    issue(4'd7, 32'd0, 32'd0, 32'h70C, 32'h20, 5'd4);
    drain();
    idle();
    @(negedge clk);
    chk("stat_branches_3", stat_branches, STATS ? 32'd3 : 32'd0);
    chk("stat_taken_2", stat_taken, STATS ? 32'd2 : 32'd0);
    gnt_mode = 1'b0;
    issue(4'd1, 32'd1, 32'd1, 32'h800, 32'h20, 5'd8);
    idle(); idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(cdb_req), 32'd0);
    chk("rst_outputs", 32'(CDB_BRA_ROB_index) | CDB_BRA_data | 32'(bra_taken) | bra_target, 32'd0);
    chk("rst_busy", 32'(func_busy), 32'd0);
    chk("rst_stats", stat_branches | stat_taken, 32'd0);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
